// File: rtl/irq_ctrl.sv
// HuC6280 interrupt controller: source sync, mask/status registers,
// timer acknowledge and prioritized vector handshake to the CPU core.
module irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        CEI_n,
  input  logic        re,
  input  logic        we,
  input  logic        addr,
  input  logic [7:0]  dIn,
  output logic [7:0]  dOut,
  input  logic        TIQ_n,
  input  logic        IRQ1_n,
  input  logic        IRQ2_n,
  output logic        TIQ_ack,
  output logic        irq_n,
  input  logic        vec_rd,
  input  logic        vec_done,
  output logic [15:0] vec_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] vec_nx;
  logic [2:0]  mask;
  logic [2:0]  pend;
  logic [2:0]  act;
  logic        irq1_s1;
  logic        irq1_s2;
  logic        irq2_s1;
  logic        irq2_s2;
  logic        mask_wr;
  logic        ack_wr;
  logic        unused_din;

  assign unused_din = ^dIn[7:3];

  assign mask_wr = ~CEI_n & we & ~addr;
  assign ack_wr  = ~CEI_n & we & addr;

  assign pend = {~TIQ_n, ~irq1_s2, ~irq2_s2};
  assign act  = pend & ~mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq1_s1  <= 1'b1;
      irq1_s2  <= 1'b1;
      irq2_s1  <= 1'b1;
      irq2_s2  <= 1'b1;
      mask     <= 3'b000;
      TIQ_ack  <= 1'b0;
      state    <= IDLE;
      vec_addr <= 16'hFFF6;
    end else if (clk_en) begin
      irq1_s1  <= IRQ1_n;
      irq1_s2  <= irq1_s1;
      irq2_s1  <= IRQ2_n;
      irq2_s2  <= irq2_s1;
      if (mask_wr)
        mask <= dIn[2:0];
      // one full clk_en period, extended by a back-to-back write
      TIQ_ack  <= ack_wr;
      state    <= state_nx;
      vec_addr <= vec_nx;
    end
  end

  always_comb begin
    state_nx = state;
    vec_nx   = vec_addr;
    irq_n    = 1'b1;
    unique case (state)
      IDLE: begin
        if (|act)
          state_nx = REQ;
      end
      REQ: begin
        irq_n = 1'b0;
        if (vec_rd) begin
          state_nx = HOLD;
          if (act[2])
            vec_nx = 16'hFFFA;
          else if (act[1])
            vec_nx = 16'hFFF8;
          else
            vec_nx = 16'hFFF6;
        end else if (act == 3'b000) begin
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (vec_done)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dOut = 8'h00;
    if (~CEI_n & re)
      dOut = addr ? {5'b0, pend} : {5'b0, mask};
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

HuC6280 interrupt controller. It sits directly downstream of the timer block. It collects the timer request (TIQ_n) and the two external lines (IRQ1_n, IRQ2_n), applies the disable mask, and exposes the mask/status registers at $1402/$1403. It returns the acknowledge pulse to the timer and presents one prioritized request plus a latched vector to the CPU core through a request/fetch/done handshake.

## Interface

- No parameters.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- clk_en  in  1  global cycle enable; all state updates only on clk edges with clk_en=1.
- CEI_n  in  1  chip enable for the interrupt register page, active-low.
- re  in  1  register read strobe.
- we  in  1  register write strobe.
- addr  in  1  register select: 0 = $1402 (mask), 1 = $1403 (status/ack).
- dIn  in  8  write data.
- dOut  out  8  read data; 0 when not selected.
- TIQ_n  in  1  timer request, active-low, already synchronous to clk.
- IRQ1_n  in  1  external IRQ1 (VDC), active-low level, asynchronous.
- IRQ2_n  in  1  external IRQ2/BRK line, active-low level, asynchronous.
- TIQ_ack  out  1  acknowledge to the timer, active-high.
- irq_n  out  1  interrupt request to the CPU core, active-low.
- vec_rd  in  1  CPU vector fetch strobe, one clk_en cycle.
- vec_done  in  1  CPU finished pushing state and loading the PC, one clk_en cycle.
- vec_addr  out  16  latched vector address.

## Operation

- **Source bit order (mask and status):** bit0 = IRQ2, bit1 = IRQ1, bit2 = TIQ.
- **Synchronizers:** IRQ1_n and IRQ2_n each pass through a 2-flop synchronizer clocked on clk_en. Reset value of every sync flop is 1 (inactive). TIQ_n is used directly.
- **Raw pending:** pend[2:0] = {~TIQ_n, ~irq1_s2, ~irq2_s2}.
- **Active set:** act = pend & ~mask.
- **Mask register (mask[2:0]):** written when ~CEI_n & we & ~addr & clk_en; takes dIn[2:0]. Reset value 3'b000.
- **Reads (combinational, like the timer):**
  - ~CEI_n & re & ~addr -> dOut = {5'b0, mask}.
  - ~CEI_n & re & addr -> dOut = {5'b0, pend}.
  - Otherwise dOut = 0.
- **Acknowledge write:** any write to $1403 (value ignored) with clk_en sets TIQ_ack.
  - TIQ_ack clears on the next clk_en edge, so it is high for exactly one clk_en period and the timer always samples it.
  - A new $1403 write during that period keeps it high for one more period.
- **Priority:** TIQ > IRQ1 > IRQ2.
- **Vectors:** TIQ $FFFA, IRQ1 $FFF8, IRQ2 $FFF6.
- **State machine** (state, 2 bits):
  - **IDLE:** irq_n=1. If act != 0 -> REQ. vec_rd and vec_done are ignored.
  - **REQ:** irq_n=0.
    - If vec_rd: latch the vector of the highest-priority bit of act this cycle -> HOLD. If act=0 in that same cycle (spurious), latch $FFF6.
    - Else if act=0 (source withdrawn or masked): -> IDLE.
  - **HOLD:** irq_n=1; vec_addr stable. On vec_done -> IDLE. Sources and mask may change freely without effect.
- vec_addr holds its last latched value outside HOLD. Reset value $FFF6.
- The controller never clears sources itself. The timer source clears only via TIQ_ack; IRQ1/IRQ2 clear when the external line deasserts.

## Timing

- **Reset values:** state=IDLE, irq_n=1, TIQ_ack=0, mask=0, sync flops=1, vec_addr=$FFF6, dOut=0.
- **Reset mid-operation:** any state returns to IDLE on the reset edge; a pending TIQ_ack is dropped.
- All latencies below count clk_en edges.
- **IRQ1_n/IRQ2_n path:** line low before edge E0 -> irq2_s2/irq1_s2 low after E1 -> state REQ and irq_n=0 after E2.
- **TIQ_n path:** low before E0 -> irq_n=0 after E0.
- **Mask write:** the new mask affects act on the following edge. Masking the only active source while in REQ -> IDLE and irq_n=1 one edge later.
- **vec_rd in REQ at edge E:** vec_addr is valid and irq_n=1 after E.
- **vec_done in HOLD at edge E:** IDLE after E. If act is still nonzero, REQ after E+1 (minimum one idle edge between requests).
- **$1403 write at edge E:** TIQ_ack=1 after E and cleared after E+1. Timer TIQ_n rises after E+1, and pend[2] clears after E+1.
- **vec_rd and a mask write in the same edge:** the vector is selected using the pre-write mask.
- **Stalls:** with clk_en=0, every register holds; dOut still tracks its inputs combinationally.

## Test plan

- **Reset defaults:** reset, then read $1402 and $1403 -> dOut=0, irq_n=1, vec_addr=$FFF6, TIQ_ack=0.
- **External latency:** hold IRQ1_n low with clk_en always 1 -> irq_n=0 after exactly 3 edges. Pulse vec_rd -> vec_addr=$FFF8, irq_n=1. Pulse vec_done -> IDLE.
- **Priority:** assert TIQ_n, IRQ1_n and IRQ2_n together, then vec_rd -> $FFFA. Write $1403 -> TIQ_ack high for one clk_en period and pend reads 3'b011. Next cycle -> $FFF8.
- **Mask:** write $1402=3'b010 with IRQ1 active -> irq_n returns high within one edge and $1403 still reads bit1=1. Write $1402=0 -> irq_n=0 again.
- **Withdrawal and spurious fetch:** in REQ, release IRQ2_n -> IDLE after sync delay. Separately, deassert the source and pulse vec_rd in the same edge -> vec_addr=$FFF6, HOLD.
- **clk_en gating and mid-operation reset:** run with clk_en=1 every 3rd clk; $1403 write -> TIQ_ack spans one full clk_en period (3 clks). Assert reset while in HOLD -> IDLE with all reset values.
